// File: rtl/led_bar_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_bar_ctrl
// Description : Display scheduler for one led_bar shared by two sensor
//               channels. Samples arrive over valid/ready, are clamped to
//               [VAL_L, VAL_U] and age out to "stale" after STALE_CYC cycles
//               without refresh. The bar shows either the manually selected
//               channel or rotates every DWELL_CYC cycles, with a single
//               blank cycle on each switch. Blink flags warning-range or
//               stale data.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               s0_valid/value/ready  - channel 0 sample handshake
//               s1_valid/value/ready  - channel 1 sample handshake
//               auto, sel             - auto-rotate enable, manual select
//               bar_en/value/blink    - registered drive to led_bar
//               cur_ch                - channel currently on the bar
// Revision    : 1.0 - initial release
// ============================================================================
module led_bar_ctrl #(
  parameter int VAL_BITS  = 3,
  parameter int VAL_L     = 0,
  parameter int VAL_U     = 7,
  parameter int WARN      = 6,
  parameter int STALE_CYC = 1000,
  parameter int DWELL_CYC = 500,
  parameter int CNT_BITS  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s0_valid,
  input  logic [VAL_BITS-1:0] s0_value,
  output logic                s0_ready,
  input  logic                s1_valid,
  input  logic [VAL_BITS-1:0] s1_value,
  output logic                s1_ready,
  input  logic                auto,
  input  logic                sel,
  output logic                bar_en,
  output logic [VAL_BITS-1:0] bar_value,
  output logic                bar_blink,
  output logic                cur_ch
);

  localparam logic [VAL_BITS-1:0] c_VAL_L      = VAL_BITS'(VAL_L);
  localparam logic [VAL_BITS-1:0] c_VAL_U      = VAL_BITS'(VAL_U);
  localparam logic [VAL_BITS-1:0] c_WARN       = VAL_BITS'(WARN);
  localparam logic [CNT_BITS-1:0] c_STALE      = CNT_BITS'(STALE_CYC);
  localparam logic [CNT_BITS-1:0] c_DWELL_LAST = CNT_BITS'(DWELL_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Handshake: ready is held low through the first cycle after reset.
  // --------------------------------------------------------------------------
  logic r_ready;

  always_ff @(posedge clk) begin
    if (reset) r_ready <= 1'b0;
    else       r_ready <= 1'b1;
  end

  assign s0_ready = r_ready;
  assign s1_ready = r_ready;

  // --------------------------------------------------------------------------
  // Per-channel sample storage and staleness tracking
  // --------------------------------------------------------------------------
  logic                w_valid [2];
  logic [VAL_BITS-1:0] w_in    [2];
  logic [VAL_BITS-1:0] w_clamp [2];
  logic [VAL_BITS-1:0] r_held  [2];
  logic                r_have  [2];
  logic                r_stale [2];
  logic [CNT_BITS-1:0] r_scnt  [2];

  assign w_valid[0] = s0_valid;
  assign w_valid[1] = s1_valid;
  assign w_in[0]    = s0_value;
  assign w_in[1]    = s1_value;

  genvar g;
  for (g = 0; g < 2; g++) begin : g_ch
    logic [VAL_BITS-1:0] w_lo;
    logic                w_acc;

    // Clamp comparisons are only built when the bound is not already the
    // natural limit of the sample width.
    if (VAL_L > 0) begin : g_lo
      assign w_lo = (w_in[g] < c_VAL_L) ? c_VAL_L : w_in[g];
    end else begin : g_lo_pass
      assign w_lo = w_in[g];
    end

    if (VAL_U < (1 << VAL_BITS) - 1) begin : g_hi
      assign w_clamp[g] = (w_lo > c_VAL_U) ? c_VAL_U : w_lo;
    end else begin : g_hi_pass
      assign w_clamp[g] = w_lo;
    end

    assign w_acc = w_valid[g] & r_ready;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_held[g]  <= '0;
        r_have[g]  <= 1'b0;
        r_stale[g] <= 1'b0;
        r_scnt[g]  <= '0;
      end else if (w_acc) begin
        r_held[g]  <= w_clamp[g];
        r_have[g]  <= 1'b1;
        r_stale[g] <= 1'b0;
        r_scnt[g]  <= '0;
      end else if (r_scnt[g] != c_STALE) begin
        // Saturating age counter; stale rises on the edge it saturates.
        r_scnt[g] <= r_scnt[g] + 1'b1;
        if (r_scnt[g] + 1'b1 == c_STALE) r_stale[g] <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Target channel: follows sel in manual mode, rotates on dwell expiry in
  // auto mode. Rotation is skipped when the other channel has nothing fresh.
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic                r_tgt;
  logic [CNT_BITS-1:0] r_dwell;
  logic                w_other;
  logic                w_other_ok;

  assign w_other    = ~r_tgt;
  assign w_other_ok = r_have[w_other] & ~r_stale[w_other];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tgt   <= 1'b0;
      r_dwell <= '0;
    end else if (!auto) begin
      r_tgt   <= sel;
      r_dwell <= '0;
    end else if (r_state == S_SHOW) begin
      // The counter keeps running through the SHOW cycle that detects the
      // switch, so expiry-to-expiry spacing is DWELL_CYC+1 including BLANK.
      if (r_dwell == c_DWELL_LAST) begin
        r_dwell <= '0;
        if (w_other_ok) r_tgt <= w_other;
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Display FSM with registered outputs
  // --------------------------------------------------------------------------
  state_t              w_state_nx;
  logic                r_cur_ch;
  logic                w_ch_nx;
  logic                r_en;
  logic                w_en_nx;
  logic [VAL_BITS-1:0] r_value;
  logic [VAL_BITS-1:0] w_value_nx;
  logic                r_blink;
  logic                w_blink_nx;
  logic                w_src;
  logic [VAL_BITS-1:0] w_src_val;
  logic                w_src_blink;

  // Channel whose data would be shown on the next edge: the current one while
  // staying in SHOW, otherwise the target being switched to.
  assign w_src       = (r_state == S_SHOW) ? r_cur_ch : r_tgt;
  assign w_src_val   = r_held[w_src];
  assign w_src_blink = (w_src_val >= c_WARN) | r_stale[w_src];

  always_comb begin
    w_state_nx = r_state;
    w_ch_nx    = r_cur_ch;
    w_en_nx    = 1'b0;
    w_value_nx = '0;
    w_blink_nx = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Bar is dark, so cur_ch can track the target without a blank.
        w_ch_nx = r_tgt;
        if (r_have[r_tgt]) begin
          w_state_nx = S_SHOW;
          w_en_nx    = 1'b1;
          w_value_nx = w_src_val;
          w_blink_nx = w_src_blink;
        end
      end
      S_SHOW: begin
        if (r_tgt != r_cur_ch) begin
          w_state_nx = S_BLANK;
        end else begin
          w_en_nx    = 1'b1;
          w_value_nx = w_src_val;
          w_blink_nx = w_src_blink;
        end
      end
      S_BLANK: begin
        w_ch_nx = r_tgt;
        if (r_have[r_tgt]) begin
          w_state_nx = S_SHOW;
          w_en_nx    = 1'b1;
          w_value_nx = w_src_val;
          w_blink_nx = w_src_blink;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cur_ch <= 1'b0;
      r_en     <= 1'b0;
      r_value  <= '0;
      r_blink  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cur_ch <= w_ch_nx;
      r_en     <= w_en_nx;
      r_value  <= w_value_nx;
      r_blink  <= w_blink_nx;
    end
  end

  assign bar_en    = r_en;
  assign bar_value = r_value;
  assign bar_blink = r_blink;
  assign cur_ch    = r_cur_ch;

endmodule
`default_nettype wire

// File: tb/tb_led_bar_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_bar_ctrl
// Description : Self-checking bench for led_bar_ctrl. A behavioural model
//               tracks each channel's clamped value, data-present flag and
//               age since last accepted sample; the bar content seen on each
//               edge is compared against the model state from the previous
//               edge. Directed phases cover reset, manual display, clamping,
//               manual switching, auto rotation, single-channel auto, stale
//               detection and reset mid-display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_bar_ctrl;

  localparam int VB    = 3;
  localparam int VL    = 2;
  localparam int VU    = 5;
  localparam int WN    = 5;
  localparam int STALE = 1000;
  localparam int DWELL = 500;
  localparam int CB    = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          s0_valid, s1_valid;
  logic [VB-1:0] s0_value, s1_value;
  logic          s0_ready, s1_ready;
  logic          auto_i, sel;
  logic          bar_en, bar_blink, cur_ch;
  logic [VB-1:0] bar_value;

  always #5 clk = ~clk;

  led_bar_ctrl #(
    .VAL_BITS (VB),
    .VAL_L    (VL),
    .VAL_U    (VU),
    .WARN     (WN),
    .STALE_CYC(STALE),
    .DWELL_CYC(DWELL),
    .CNT_BITS (CB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s0_valid (s0_valid),
    .s0_value (s0_value),
    .s0_ready (s0_ready),
    .s1_valid (s1_valid),
    .s1_value (s1_value),
    .s1_ready (s1_ready),
    .auto     (auto_i),
    .sel      (sel),
    .bar_en   (bar_en),
    .bar_value(bar_value),
    .bar_blink(bar_blink),
    .cur_ch   (cur_ch)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (after the most recent edge)
  int m_held [2];
  bit m_have [2];
  int m_age  [2];
  bit m_rdy;
  // Model state before the most recent edge: what the bar must show now
  int p_held [2];
  bit p_have [2];
  bit p_stale[2];

  function automatic int clampv(input int v);
    if (v < VL) return VL;
    if (v > VU) return VU;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge: update the model with the inputs present at the edge,
  // then check the DUT outputs 1 time unit later.
  task automatic tick();
    bit rst_edge;
    bit vld[2];
    int vals[2];
    int ch;
    @(posedge clk);
    rst_edge = reset;
    vld[0]   = s0_valid;
    vld[1]   = s1_valid;
    vals[0]  = int'(s0_value);
    vals[1]  = int'(s1_value);
    for (int c = 0; c < 2; c++) begin
      p_held[c]  = m_held[c];
      p_have[c]  = m_have[c];
      p_stale[c] = (m_age[c] >= STALE);
    end
    if (rst_edge) begin
      for (int c = 0; c < 2; c++) begin
        m_held[c] = 0;
        m_have[c] = 1'b0;
        m_age[c]  = 0;
      end
      m_rdy = 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (vld[c] && m_rdy) begin
          m_held[c] = clampv(vals[c]);
          m_have[c] = 1'b1;
          m_age[c]  = 0;
        end else if (m_age[c] < STALE) begin
          m_age[c]++;
        end
      end
      m_rdy = 1'b1;
    end
    #1;
    check("s0_ready", s0_ready, m_rdy);
    check("s1_ready", s1_ready, m_rdy);
    if (rst_edge) begin
      check("rst_bar_en", bar_en, 0);
      check("rst_bar_value", bar_value, 0);
      check("rst_bar_blink", bar_blink, 0);
      check("rst_cur_ch", cur_ch, 0);
    end else if (bar_en === 1'b1) begin
      ch = (cur_ch === 1'b1) ? 1 : 0;
      check("shown_has_data", p_have[ch], 1);
      check("bar_value", bar_value, p_held[ch]);
      check("bar_blink", bar_blink, ((p_held[ch] >= WN) || p_stale[ch]) ? 1 : 0);
    end else begin
      check("bar_en_known", bar_en, 0);
    end
  endtask

  initial begin
    int lows;
    int low_run;
    int last_blank;
    int n_blank;

    reset    = 1'b1;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    s0_value = '0;
    s1_value = '0;
    auto_i   = 1'b0;
    sel      = 1'b0;
    m_rdy    = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_held[c] = 0;
      m_have[c] = 1'b0;
      m_age[c]  = 0;
    end

    // Reset held for 3 cycles; ready rises one cycle after release.
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("ready_low_after_release", s0_ready, 0);
    repeat (4) tick();
    check("idle_no_data_en", bar_en, 0);

    // Manual channel 0 display, warning blink and clamping.
    s0_valid = 1'b1; s0_value = 3'd3; tick();
    s0_valid = 1'b0; tick();
    check("m_first_en", bar_en, 1);
    check("m_first_value", bar_value, 3);
    check("m_first_blink", bar_blink, 0);
    s0_valid = 1'b1; s0_value = 3'd6; tick();
    s0_valid = 1'b0; tick();
    check("m_warn_value", bar_value, 5);
    check("m_warn_blink", bar_blink, 1);
    s0_valid = 1'b1; s0_value = 3'd0; tick();
    s0_valid = 1'b0; tick();
    check("clamp_low", bar_value, 2);
    check("clamp_low_blink", bar_blink, 0);
    s0_valid = 1'b1; s0_value = 3'd7; tick();
    s0_valid = 1'b0; tick();
    check("clamp_high", bar_value, 5);

    // Randomized manual traffic on both channels with occasional sel changes.
    for (int t = 0; t < 300; t++) begin
      s0_valid = 1'($urandom_range(0, 1));
      s1_valid = 1'($urandom_range(0, 1));
      s0_value = VB'($urandom_range(0, 7));
      s1_value = VB'($urandom_range(0, 7));
      if ((t % 20) == 0) sel = 1'($urandom_range(0, 1));
      tick();
    end
    s0_valid = 1'b0; s1_valid = 1'b0; sel = 1'b0;
    repeat (5) tick();
    check("settle_ch0_en", bar_en, 1);
    check("settle_ch0_cur", cur_ch, 0);

    // Manual switch to channel 1: exactly one blank cycle.
    s1_valid = 1'b1; s1_value = 3'd4; tick();
    s1_valid = 1'b0; sel = 1'b1;
    lows = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (bar_en === 1'b0) lows++;
    end
    check("man_switch_blank_len", lows, 1);
    check("man_switch_cur", cur_ch, 1);
    check("man_switch_value", bar_value, 4);

    // Auto rotation with both channels refreshed every 100 cycles; sel noise.
    auto_i = 1'b1;
    low_run = 0; last_blank = -1; n_blank = 0;
    for (int t = 0; t < 3100; t++) begin
      s0_valid = ((t % 100) == 0);
      s1_valid = ((t % 100) == 0);
      s0_value = 3'd2;
      s1_value = 3'd4;
      sel      = 1'($urandom_range(0, 1));
      tick();
      if (bar_en === 1'b0) begin
        if (low_run == 0) begin
          if (last_blank >= 0) check("dwell_period", t - last_blank, DWELL + 1);
          last_blank = t;
          n_blank++;
        end
        low_run++;
      end else if (low_run > 0) begin
        check("auto_blank_len", low_run, 1);
        low_run = 0;
      end
    end
    check("auto_switch_count_ok", (n_blank >= 5) ? 1 : 0, 1);
    s0_valid = 1'b0; s1_valid = 1'b0;

    // Fresh start with channel 1 never sent: no rotation, no blanks.
    reset = 1'b1; repeat (2) tick();
    reset = 1'b0; tick();
    s0_valid = 1'b1; s0_value = 3'd3; tick();
    s0_valid = 1'b0; tick();
    check("solo_en", bar_en, 1);
    for (int t = 0; t < 1500; t++) begin
      s0_valid = ((t % 100) == 0);
      s0_value = VB'($urandom_range(0, 4));
      sel      = 1'($urandom_range(0, 1));
      tick();
      check("solo_no_blank", bar_en, 1);
      check("solo_cur", cur_ch, 0);
    end

    // Stop feeding channel 0: blink appears once the data is stale.
    s0_valid = 1'b1; s0_value = 3'd3; tick();
    s0_valid = 1'b0;
    for (int t = 1; t <= STALE + 10; t++) begin
      tick();
      check("stale_blink", bar_blink, (t >= STALE + 1) ? 1 : 0);
    end
    s0_valid = 1'b1; s0_value = 3'd1; tick();
    s0_valid = 1'b0; tick();
    check("refresh_value", bar_value, 2);
    check("refresh_blink", bar_blink, 0);

    // Reset while showing: bar goes dark on the next edge, data discarded.
    reset = 1'b1; tick();
    check("mid_reset_en", bar_en, 0);
    reset = 1'b0;
    repeat (3) tick();
    check("post_reset_dark", bar_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
